// File: rtl/dbg_bus_master.sv
// Debug register bus initiator: parses 'W'/'R' byte commands and runs single bus transactions.
// Optional strobe timeout is enabled by defining DBG_BUS_TIMEOUT_EN.
module dbg_bus_master #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  dbg_a,
  output logic [15:0] dbg_di,
  input  logic [15:0] dbg_do,
  output logic        dbg_we,
  output logic        dbg_rd,
  input  logic        dbg_ready,
  output logic        busy
);

  if (TIMEOUT_CYCLES < 2) begin : gParamCheck
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [3:0] {
    IDLE, ADDR, DHI, DLO, XFER, TX_HI, TX_LO, TX_ACK, TX_NAK, TX_ERR
  } state_t;

  state_t      state_q;
  logic        isWrite_q;
  logic [7:0]  dbgA_q;
  logic [15:0] dbgDi_q;
  logic        we_q;
  logic        rd_q;
  logic [15:0] rdata_q;
  logic [7:0]  txData_q;
  logic        txValid_q;

`ifdef DBG_BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q;
`endif

  // The counter sits at zero outside XFER, so every strobe starts counting from 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      isWrite_q <= 1'b0;
      dbgA_q    <= '0;
      dbgDi_q   <= '0;
      we_q      <= 1'b0;
      rd_q      <= 1'b0;
      rdata_q   <= '0;
      txData_q  <= '0;
      txValid_q <= 1'b0;
`ifdef DBG_BUS_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
`ifdef DBG_BUS_TIMEOUT_EN
      if (state_q != XFER) cnt_q <= '0;
`endif
      case (state_q)
        IDLE: begin
          if (rx_valid) begin
            if (rx_data == 8'h57 || rx_data == 8'h52) begin
              isWrite_q <= (rx_data == 8'h57);
              state_q   <= ADDR;
            end else begin
              txData_q  <= 8'h3F;
              txValid_q <= 1'b1;
              state_q   <= TX_NAK;
            end
          end
        end
        ADDR: begin
          if (rx_valid) begin
            dbgA_q <= rx_data;
            if (isWrite_q) begin
              state_q <= DHI;
            end else begin
              rd_q    <= 1'b1;
              state_q <= XFER;
            end
          end
        end
        DHI: begin
          if (rx_valid) begin
            dbgDi_q[15:8] <= rx_data;
            state_q       <= DLO;
          end
        end
        DLO: begin
          if (rx_valid) begin
            dbgDi_q[7:0] <= rx_data;
            we_q         <= 1'b1;
            state_q      <= XFER;
          end
        end
        // Leave on the first ready edge so exactly one ready cycle is consumed.
        XFER: begin
          if (dbg_ready) begin
            we_q      <= 1'b0;
            rd_q      <= 1'b0;
            txValid_q <= 1'b1;
            if (isWrite_q) begin
              txData_q <= 8'h2B;
              state_q  <= TX_ACK;
            end else begin
              rdata_q  <= dbg_do;
              txData_q <= dbg_do[15:8];
              state_q  <= TX_HI;
            end
          end
`ifdef DBG_BUS_TIMEOUT_EN
          else if (cnt_q == LIMIT) begin
            we_q      <= 1'b0;
            rd_q      <= 1'b0;
            txValid_q <= 1'b1;
            txData_q  <= 8'h21;
            state_q   <= TX_ERR;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        TX_HI: begin
          if (tx_ready) begin
            txData_q <= rdata_q[7:0];
            state_q  <= TX_LO;
          end
        end
        TX_LO, TX_ACK, TX_NAK, TX_ERR: begin
          if (tx_ready) begin
            txValid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_ready = (state_q == IDLE) || (state_q == ADDR) ||
                    (state_q == DHI)  || (state_q == DLO);
  assign busy     = (state_q != IDLE);
  assign tx_data  = txData_q;
  assign tx_valid = txValid_q;
  assign dbg_a    = dbgA_q;
  assign dbg_di   = dbgDi_q;
  assign dbg_we   = we_q;
  assign dbg_rd   = rd_q;

endmodule

// File: tb/tb_dbg_bus_master.sv
// Directed, table-driven bench for dbg_bus_master with a delay-programmable bus responder.
// Timeout sequence is exercised only when DBG_BUS_TIMEOUT_EN is defined.
module tb_dbg_bus_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  dbg_a;
  logic [15:0] dbg_di;
  logic [15:0] dbg_do;
  logic        dbg_we;
  logic        dbg_rd;
  logic        dbg_ready;
  logic        busy;

  dbg_bus_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .dbg_a(dbg_a), .dbg_di(dbg_di), .dbg_do(dbg_do),
    .dbg_we(dbg_we), .dbg_rd(dbg_rd), .dbg_ready(dbg_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Responder: ready comes readyDelay cycles after the strobe rises (0 = same cycle).
  int          strobeAge = 0;
  int          readyDelay = 0;
  logic        readyStuck = 1'b0;
  logic [15:0] respData = '0;

  always @(posedge clk) strobeAge <= (dbg_we || dbg_rd) ? strobeAge + 1 : 0;
  assign dbg_ready = (dbg_we || dbg_rd) && !readyStuck && (strobeAge >= readyDelay);
  assign dbg_do    = respData;

  // Strobe monitor, sampled just after each rising edge.
  int          weCycles = 0;
  int          rdCycles = 0;
  int          bothCycles = 0;
  logic [7:0]  seenA = '0;
  logic [15:0] seenDi = '0;

  always @(posedge clk) begin
    #1;
    if (dbg_we) weCycles++;
    if (dbg_rd) rdCycles++;
    if (dbg_we && dbg_rd) bothCycles++;
    if (dbg_we || dbg_rd) begin
      seenA  = dbg_a;
      seenDi = dbg_di;
    end
  end

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          delay;
    int          nTx;
    logic [7:0]  tx0;
    logic [7:0]  tx1;
    int          lat;
    int          weExp;
    int          rdExp;
  } vec_t;

  vec_t vecs[6];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (rx_ready) @(negedge clk);
    else checkOutput("rx_accept_timeout", 32'(rx_ready), 32'd1);
    rx_valid = 1'b0;
  endtask

  task automatic recvByte(output logic [7:0] b, output int waited);
    int n = 0;
    while (!tx_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    waited = n;
    b = tx_data;
    if (tx_valid) @(negedge clk);
    else checkOutput("tx_wait_timeout", 32'(tx_valid), 32'd1);
  endtask

  task automatic clearMonitor();
    weCycles = 0;
    rdCycles = 0;
  endtask

  task automatic applyStimulus(input vec_t v);
    clearMonitor();
    readyDelay = v.delay;
    respData   = v.rdata;
    sendByte(v.cmd);
    if (v.cmd == 8'h57 || v.cmd == 8'h52) sendByte(v.addr);
    if (v.cmd == 8'h57) begin
      sendByte(v.wdata[15:8]);
      sendByte(v.wdata[7:0]);
    end
  endtask

  task automatic checkVector(input int idx, input vec_t v);
    logic [7:0] b;
    int         w;
    recvByte(b, w);
    checkOutput($sformatf("v%0d_tx0", idx), 32'(b), 32'(v.tx0));
    checkOutput($sformatf("v%0d_latency", idx), 32'(w), 32'(v.lat));
    if (v.nTx > 1) begin
      recvByte(b, w);
      checkOutput($sformatf("v%0d_tx1", idx), 32'(b), 32'(v.tx1));
    end
    checkOutput($sformatf("v%0d_we_cycles", idx), 32'(weCycles), 32'(v.weExp));
    checkOutput($sformatf("v%0d_rd_cycles", idx), 32'(rdCycles), 32'(v.rdExp));
    if (v.weExp + v.rdExp > 0) checkOutput($sformatf("v%0d_addr", idx), 32'(seenA), 32'(v.addr));
    if (v.weExp > 0) checkOutput($sformatf("v%0d_wdata", idx), 32'(seenDi), 32'(v.wdata));
    checkOutput($sformatf("v%0d_idle", idx), {30'd0, busy, tx_valid}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] b;
    int         w;
    bit         ok;

    vecs[0] = '{8'h57, 8'h1B, 16'h1234, 16'h0000, 0, 1, 8'h2B, 8'h00, 1, 1, 0};
    vecs[1] = '{8'h52, 8'h20, 16'h0000, 16'hBEEF, 5, 2, 8'hBE, 8'hEF, 6, 0, 6};
    vecs[2] = '{8'h41, 8'h00, 16'h0000, 16'h0000, 0, 1, 8'h3F, 8'h00, 0, 0, 0};
    vecs[3] = '{8'h57, 8'h05, 16'hABCD, 16'h0000, 3, 1, 8'h2B, 8'h00, 4, 4, 0};
    vecs[4] = '{8'h52, 8'h7F, 16'h0000, 16'h0001, 0, 2, 8'h00, 8'h01, 1, 0, 1};
    vecs[5] = '{8'h00, 8'h00, 16'h0000, 16'h0000, 0, 1, 8'h3F, 8'h00, 0, 0, 0};

    rst_n    = 1'b0;
    rx_data  = '0;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_rx_ready", 32'(rx_ready), 32'd1);
    checkOutput("rst_tx", {23'd0, tx_valid, tx_data}, 32'd0);
    checkOutput("rst_dbg_a", 32'(dbg_a), 32'd0);
    checkOutput("rst_dbg_di", 32'(dbg_di), 32'd0);
    checkOutput("rst_strobes_busy", {29'd0, dbg_we, dbg_rd, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      checkVector(i, vecs[i]);
      @(negedge clk);
    end

    // Backpressure: response byte must hold while the host stalls.
    tx_ready = 1'b0;
    clearMonitor();
    readyDelay = 0;
    respData   = 16'hA55A;
    sendByte(8'h52);
    sendByte(8'h33);
    w = 0;
    while (!tx_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!(tx_valid && tx_data == 8'hA5 && !rx_ready && busy)) ok = 1'b0;
      @(negedge clk);
    end
    checkOutput("bp_hold", 32'(ok), 32'd1);
    tx_ready = 1'b1;
    recvByte(b, w);
    checkOutput("bp_hi", 32'(b), 32'hA5);
    recvByte(b, w);
    checkOutput("bp_lo", 32'(b), 32'h5A);
    checkOutput("bp_rd_cycles", 32'(rdCycles), 32'd1);
    checkOutput("bp_idle", 32'(busy), 32'd0);

`ifdef DBG_BUS_TIMEOUT_EN
    readyStuck = 1'b1;
    clearMonitor();
    sendByte(8'h57);
    sendByte(8'h44);
    sendByte(8'hCA);
    sendByte(8'hFE);
    recvByte(b, w);
    checkOutput("to_err_byte", 32'(b), 32'h21);
    checkOutput("to_latency", 32'(w), 32'd16);
    checkOutput("to_we_cycles", 32'(weCycles), 32'd16);
    checkOutput("to_idle", {30'd0, busy, tx_valid}, 32'd0);
    readyStuck = 1'b0;
    readyDelay = 0;
    respData   = 16'h1357;
    clearMonitor();
    sendByte(8'h52);
    sendByte(8'h10);
    recvByte(b, w);
    checkOutput("to_after_hi", 32'(b), 32'h13);
    recvByte(b, w);
    checkOutput("to_after_lo", 32'(b), 32'h57);
    checkOutput("to_after_addr", 32'(seenA), 32'h10);
`endif

    // Reset in the middle of a stalled read must kill the strobe and any response.
    readyStuck = 1'b1;
    clearMonitor();
    sendByte(8'h52);
    sendByte(8'h20);
    repeat (3) @(negedge clk);
    checkOutput("mid_rd_high", {30'd0, dbg_rd, rx_ready}, 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_drop", {29'd0, dbg_rd, tx_valid, busy}, 32'd0);
    rst_n = 1'b1;
    readyStuck = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (tx_valid || dbg_rd || dbg_we) ok = 1'b0;
      @(negedge clk);
    end
    checkOutput("mid_no_response", 32'(ok), 32'd1);
    checkOutput("mid_rx_ready", 32'(rx_ready), 32'd1);

    checkOutput("never_both_strobes", 32'(bothCycles), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
